// File: rtl/lockin_polar_if.sv
// Lock-in I/Q result in, polar magnitude/phase out.
// The source drives the master side; the converter takes the slave side.
interface lockin_polar_if #(
    parameter int Q_IN    = 32,
    parameter int Q_PHASE = 16
);
    logic signed [Q_IN-1:0]    fase_in;
    logic signed [Q_IN-1:0]    cuad_in;
    logic                      in_valid;
    logic        [Q_IN-1:0]    mag_out;
    logic signed [Q_PHASE-1:0] phase_out;
    logic                      out_valid;
    logic                      busy;
    logic                      overrun;

    modport master (
        output fase_in, cuad_in, in_valid,
        input  mag_out, phase_out, out_valid, busy, overrun
    );

    modport slave (
        input  fase_in, cuad_in, in_valid,
        output mag_out, phase_out, out_valid, busy, overrun
    );
endinterface

// File: rtl/lockin_polar.sv
// Iterative vectoring CORDIC: converts the lock-in I/Q pair into
// magnitude and phase, one micro-rotation per clock.
module lockin_polar #(
    parameter int Q_IN    = 32,
    parameter int ITER    = 16,
    parameter int Q_PHASE = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    lockin_polar_if.slave bus
);
    // Fractional guard bits keep shift truncation below one phase LSB.
    localparam int  G  = 8;
    localparam int  W  = Q_IN + 2 + G;
    localparam int  PW = W + 16;
    localparam real PI = 3.14159265358979323846;

    localparam logic [PW-1:0] INV_K = PW'(39797);
    localparam logic [PW-1:0] HALF  =
        {{(PW-16-G){1'b0}}, 1'b1, {(15+G){1'b0}}};

    localparam logic [15:0] TAB16 [16] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297,
        16'd651,  16'd326,  16'd163,  16'd81,
        16'd41,   16'd20,   16'd10,   16'd5,
        16'd3,    16'd1,    16'd1,    16'd0
    };

    function automatic logic [Q_PHASE-1:0] atan_c(input int i);
        real a;
        a = $atan(2.0 ** (-i)) / (2.0 * PI) * (2.0 ** Q_PHASE);
        return Q_PHASE'($rtoi(a + 0.5));
    endfunction

    typedef enum logic [2:0] {
        IDLE, PREROT, ITERATE, SCALE, DONE
    } state_e;

    state_e               state_q, state_d;
    logic signed [W-1:0]  x_q, x_d, y_q, y_d;
    logic [Q_PHASE-1:0]   z_q, z_d;
    logic [3:0]           i_q, i_d;
    logic                 in_valid_q;
    logic [Q_IN-1:0]      mag_q, mag_d;
    logic [Q_PHASE-1:0]   phase_q, phase_d;
    logic                 out_valid_q, out_valid_d;
    logic                 overrun_q, overrun_d;

    logic [Q_PHASE-1:0]   atan_tab [16];
    logic                 start;
    logic                 rot_pos;
    logic signed [W-1:0]  xs, ys;
    logic [W-1:0]         x_pos, sc;

    for (genvar g = 0; g < 16; g++) begin : g_atan
        if (Q_PHASE == 16) begin : g_tab
            assign atan_tab[g] = TAB16[g];
        end else begin : g_calc
            assign atan_tab[g] = atan_c(g);
        end
    end

    always_comb begin
        start       = bus.in_valid & ~in_valid_q;
        rot_pos     = ~y_q[W-1];
        xs          = x_q >>> i_q;
        ys          = y_q >>> i_q;
        x_pos       = x_q[W-1] ? '0 : x_q;
        sc          = W'((PW'(x_pos) * INV_K + HALF) >> (16 + G));
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        i_d         = i_q;
        mag_d       = mag_q;
        phase_d     = phase_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q | (start & (state_q != IDLE));
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x_d = {{2{bus.fase_in[Q_IN-1]}}, bus.fase_in, {G{1'b0}}};
                    y_d = {{2{bus.cuad_in[Q_IN-1]}}, bus.cuad_in, {G{1'b0}}};
                    state_d = PREROT;
                end
            end
            PREROT: begin
                if (x_q[W-1]) begin
                    x_d = -x_q;
                    y_d = -y_q;
                    z_d = {1'b1, {(Q_PHASE-1){1'b0}}};
                end else begin
                    z_d = '0;
                end
                i_d     = '0;
                state_d = ITERATE;
            end
            ITERATE: begin
                x_d = rot_pos ? x_q + ys : x_q - ys;
                y_d = rot_pos ? y_q - xs : y_q + xs;
                z_d = rot_pos ? z_q + atan_tab[i_q] : z_q - atan_tab[i_q];
                i_d = i_q + 4'd1;
                if (i_q == 4'(ITER - 1)) state_d = SCALE;
            end
            SCALE: begin
                mag_d       = |sc[W-1:Q_IN] ? '1 : sc[Q_IN-1:0];
                // x stays zero through the rotations only for a (0,0) input
                phase_d     = (x_q == '0) ? '0 : z_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            i_q         <= '0;
            in_valid_q  <= 1'b0;
            mag_q       <= '0;
            phase_q     <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            i_q         <= i_d;
            in_valid_q  <= bus.in_valid;
            mag_q       <= mag_d;
            phase_q     <= phase_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.mag_out   = mag_q;
    assign bus.phase_out = phase_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_lockin_polar.sv
// Scoreboard bench for lockin_polar: ideal polar values are queued when
// a pair is driven and compared when out_valid pulses.
module tb_lockin_polar;
    localparam int  QI = 32;
    localparam int  IT = 16;
    localparam int  QP = 16;
    localparam real TWO_PI = 6.28318530717958647692;

    typedef struct {
        real   mag;
        real   ph;
        string name;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    lockin_polar_if #(.Q_IN(QI), .Q_PHASE(QP)) bus ();

    lockin_polar #(.Q_IN(QI), .ITER(IT), .Q_PHASE(QP)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    function automatic exp_t model(input logic signed [31:0] i,
                                   input logic signed [31:0] q,
                                   input string nm);
        exp_t e;
        real ri, rq;
        ri = real'(i);
        rq = real'(q);
        e.mag = $sqrt(ri * ri + rq * rq);
        e.ph = (i == 0 && q == 0) ? 0.0 : $atan2(rq, ri) / TWO_PI * 65536.0;
        e.name = nm;
        return e;
    endfunction

    function automatic real rabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    function automatic real ph_err(input real p, input real e);
        real d;
        d = p - e;
        if (d > 32768.0) d = d - 65536.0;
        if (d < -32768.0) d = d + 65536.0;
        return rabs(d);
    endfunction

    function automatic real mag_tol(input real m);
        return 2.0 + 0.0005 * m;
    endfunction

    task automatic drive_pulse(input logic signed [31:0] i,
                               input logic signed [31:0] q,
                               input string nm);
        @(negedge clk);
        bus.fase_in  = i;
        bus.cuad_in  = q;
        bus.in_valid = 1'b1;
        sb.push_back(model(i, q, nm));
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid; cyc counts edges since capture.
    task automatic await_result(input int c0, output int cyc,
                                output bit got, output bit busy_ok);
        cyc = c0;
        got = 1'b0;
        busy_ok = 1'b1;
        while (!got && cyc < 60) begin
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.out_valid) got = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.fase_in = '0;
        bus.cuad_in = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.mag_out !== '0) begin
            errors++;
            $display("FAIL reset_mag: got %0d want 0", bus.mag_out);
        end
        checks++;
        if (bus.phase_out !== '0) begin
            errors++;
            $display("FAIL reset_phase: got %0d want 0", bus.phase_out);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: out_valid %b busy %b want 0 0",
                     bus.out_valid, bus.busy);
        end
        checks++;
        if (bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_overrun: got %b want 0", bus.overrun);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int cyc;
        bit got, bok;
        exp_t e;
        drive_pulse(1000, 0, "basic");
        await_result(1, cyc, got, bok);
        e = sb.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL basic_timeout: no out_valid after %0d cycles", cyc);
        end else begin
            checks++;
            if (cyc !== IT + 3) begin
                errors++;
                $display("FAIL basic_latency: got %0d want %0d", cyc, IT + 3);
            end
            checks++;
            if (!bok) begin
                errors++;
                $display("FAIL basic_busy: busy low before out_valid, want 1");
            end
            checks++;
            if (rabs(real'(bus.mag_out) - e.mag) > mag_tol(e.mag)) begin
                errors++;
                $display("FAIL basic_mag: got %0d want %f", bus.mag_out, e.mag);
            end
            checks++;
            if (ph_err(real'(bus.phase_out), e.ph) > 3.0) begin
                errors++;
                $display("FAIL basic_phase: got %0d want %f",
                         bus.phase_out, e.ph);
            end
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL basic_after: out_valid %b busy %b want 0 0",
                         bus.out_valid, bus.busy);
            end
        end
    endtask

    task automatic test_angles();
        logic signed [31:0] ti [7];
        logic signed [31:0] tq [7];
        int cyc;
        bit got, bok;
        exp_t e;
        ti = '{0, -1000, 1000, 0, 32'sh8000_0000, 32'sh7fff_ffff, 123456};
        tq = '{1000, 0, -1000, 0, 32'sh8000_0000, 1, -987654};
        for (int k = 0; k < 7; k++) begin
            drive_pulse(ti[k], tq[k], $sformatf("angle%0d", k));
            await_result(1, cyc, got, bok);
            e = sb.pop_front();
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL %s_timeout: no out_valid after %0d cycles",
                         e.name, cyc);
            end else if (e.mag == 0.0) begin
                checks++;
                if (bus.mag_out !== '0 || bus.phase_out !== '0) begin
                    errors++;
                    $display("FAIL %s_zero: mag %0d phase %0d want 0 0",
                             e.name, bus.mag_out, bus.phase_out);
                end
            end else begin
                checks++;
                if (rabs(real'(bus.mag_out) - e.mag) > mag_tol(e.mag)) begin
                    errors++;
                    $display("FAIL %s_mag: got %0d want %f",
                             e.name, bus.mag_out, e.mag);
                end
                checks++;
                if (ph_err(real'(bus.phase_out), e.ph) > 3.0) begin
                    errors++;
                    $display("FAIL %s_phase: got %0d want %f",
                             e.name, bus.phase_out, e.ph);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit got, bok;
        exp_t e;
        for (int k = 0; k < 6; k++) begin
            drive_pulse($signed($urandom()), $signed($urandom()),
                        $sformatf("b2b%0d", k));
            await_result(1, cyc, got, bok);
            e = sb.pop_front();
            checks++;
            if (!got || cyc !== IT + 3) begin
                errors++;
                $display("FAIL %s_latency: got %0d want %0d",
                         e.name, cyc, IT + 3);
            end else begin
                checks++;
                if (rabs(real'(bus.mag_out) - e.mag) > mag_tol(e.mag)) begin
                    errors++;
                    $display("FAIL %s_mag: got %0d want %f",
                             e.name, bus.mag_out, e.mag);
                end
                checks++;
                if (ph_err(real'(bus.phase_out), e.ph) > 3.0) begin
                    errors++;
                    $display("FAIL %s_phase: got %0d want %f",
                             e.name, bus.phase_out, e.ph);
                end
            end
        end
    endtask

    task automatic test_hold();
        int pulses = 0;
        logic [31:0] mag = '0;
        logic signed [15:0] ph = '0;
        exp_t e;
        @(negedge clk);
        bus.fase_in = 1234;
        bus.cuad_in = -4321;
        bus.in_valid = 1'b1;
        sb.push_back(model(1234, -4321, "hold"));
        for (int k = 0; k < 110; k++) begin
            @(negedge clk);
            if (k == 99) bus.in_valid = 1'b0;
            if (bus.out_valid) begin
                pulses++;
                mag = bus.mag_out;
                ph = bus.phase_out;
            end
        end
        e = sb.pop_front();
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL hold_pulses: got %0d want 1", pulses);
        end
        checks++;
        if (rabs(real'(mag) - e.mag) > mag_tol(e.mag) ||
            ph_err(real'(ph), e.ph) > 3.0) begin
            errors++;
            $display("FAIL hold_value: mag %0d phase %0d want %f %f",
                     mag, ph, e.mag, e.ph);
        end
        checks++;
        if (bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL hold_overrun: got %b want 0", bus.overrun);
        end
    endtask

    task automatic test_overrun();
        int cyc, extra = 0;
        bit got, bok;
        exp_t e;
        drive_pulse(2000, 1500, "ovr_a");
        repeat (4) @(negedge clk);
        bus.fase_in = -7000;
        bus.cuad_in = 9;
        bus.in_valid = 1'b1;
        await_result(5, cyc, got, bok);
        e = sb.pop_front();
        checks++;
        if (!got || cyc !== IT + 3) begin
            errors++;
            $display("FAIL ovr_latency: got %0d want %0d", cyc, IT + 3);
        end
        checks++;
        if (rabs(real'(bus.mag_out) - e.mag) > mag_tol(e.mag) ||
            ph_err(real'(bus.phase_out), e.ph) > 3.0) begin
            errors++;
            $display("FAIL ovr_value: mag %0d phase %0d want %f %f",
                     bus.mag_out, bus.phase_out, e.mag, e.ph);
        end
        checks++;
        if (bus.overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_flag: got %b want 1", bus.overrun);
        end
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) extra++;
        end
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL ovr_extra: got %0d pulses want 0", extra);
        end
        checks++;
        if (bus.overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky: got %b want 1", bus.overrun);
        end
    endtask

    task automatic test_reset_abort();
        int cyc, extra = 0;
        bit got, bok;
        exp_t e;
        drive_pulse(3000, 4000, "abort");
        repeat (6) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        sb.delete();
        checks++;
        if (bus.mag_out !== '0 || bus.phase_out !== '0 ||
            bus.busy !== 1'b0 || bus.overrun !== 1'b0 ||
            bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_clear: mag %0d ph %0d busy %b ovr %b ov %b want 0",
                     bus.mag_out, bus.phase_out, bus.busy,
                     bus.overrun, bus.out_valid);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL abort_no_valid: got %0d pulses want 0", extra);
        end
        reset_n = 1'b0;
        bus.fase_in = -3000;
        bus.cuad_in = 4000;
        bus.in_valid = 1'b1;
        sb.push_back(model(-3000, 4000, "held_release"));
        @(negedge clk);
        reset_n = 1'b1;
        await_result(0, cyc, got, bok);
        e = sb.pop_front();
        bus.in_valid = 1'b0;
        checks++;
        if (!got || cyc !== IT + 3) begin
            errors++;
            $display("FAIL held_latency: got %0d want %0d", cyc, IT + 3);
        end
        checks++;
        if (rabs(real'(bus.mag_out) - e.mag) > mag_tol(e.mag) ||
            ph_err(real'(bus.phase_out), e.ph) > 3.0) begin
            errors++;
            $display("FAIL held_value: mag %0d phase %0d want %f %f",
                     bus.mag_out, bus.phase_out, e.mag, e.ph);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_angles();
        test_back_to_back();
        test_hold();
        test_overrun();
        test_reset_abort();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/lockin_polar.md
Name: lockin_polar

Overview:
- Downstream stage of the lock-in accumulator. Converts the final in-phase/quadrature accumulator pair into magnitude and phase for the SSVEP detection logic.
- Uses an iterative (one micro-rotation per clock) CORDIC in vectoring mode, with a single shared datapath.
- Treats the level-held "done" flag of the lock-in as an event: one conversion per rising edge.

Parameters:
- Q_in, 32: width of the signed fase/cuad inputs. Must equal the lock-in Q_out.
- ITER, 16: number of CORDIC micro-rotations (1..16).
- Q_phase, 16: phase width. Full circle = 2^Q_phase.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- fase_in  in  Q_in  signed in-phase accumulator (I)
- cuad_in  in  Q_in  signed quadrature accumulator (Q)
- in_valid  in  1  level; the I/Q pair is valid while high (the lock-in holds it high)
- mag_out  out  Q_in  unsigned magnitude sqrt(I²+Q²), gain-compensated
- phase_out  out  Q_phase  signed atan2(Q,I); +2^(Q_phase-2) = +90°
- out_valid  out  1  one-cycle pulse; mag_out/phase_out are valid on that cycle and held afterwards
- busy  out  1  high from capture until the out_valid cycle, inclusive
- overrun  out  1  sticky; set when a rising edge of in_valid is ignored

Behaviour:
- Reset (async, reset_n low):
  - All registers clear, including in_valid_d, state=IDLE, iteration counter, x/y/z.
  - mag_out=0, phase_out=0, out_valid=0, busy=0, overrun=0.
  - Reset asserted mid-conversion aborts it; no out_valid is produced.
- Edge detect: in_valid_d <= in_valid every clock. A start event is in_valid & ~in_valid_d.
  - A level held high produces exactly one conversion.
  - Reset clears in_valid_d to 0, so an in_valid already high at reset release counts as a rising edge.
- FSM states:
  - IDLE: on a start event, capture x=sext(fase_in), y=sext(cuad_in) into Q_in+2-bit signed registers, set busy, go to PREROT.
  - PREROT (1 cycle):
    - If x<0: x=-x, y=-y, z=2^(Q_phase-1).
    - Else z=0.
    - Go to ITERATE with i=0.
  - ITERATE (ITER cycles), with d = (y>=0):
    - x += d ? (y>>>i) : -(y>>>i)
    - y -= d ? (x>>>i) : -(x>>>i)
    - z += d ? atan_i : -atan_i
    - Use the old x/y values on the right-hand side. Shifts are arithmetic.
    - z wraps modulo 2^Q_phase.
    - After i=ITER-1, go to SCALE.
  - SCALE (1 cycle):
    - mag = (x * 39797 + 32768) >> 16, i.e. 1/K in Q16 with round-half-up.
    - Saturate to 2^Q_in - 1.
    - phase_out <= z. Go to DONE.
  - DONE (1 cycle): out_valid=1, busy=0 on the following cycle, return to IDLE.
- atan_i ROM for Q_phase=16, i=0..15: 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0.
  - For other Q_phase, entries are round(atan(2^-i)/2π · 2^Q_phase).
- Latency: start event at clock edge T (capture) → out_valid high in the cycle after edge T+ITER+2, i.e. ITER+3 cycles after capture (19 for defaults).
- Busy/overrun: a start event while busy is ignored and sets overrun; the conversion in flight is unaffected. A start event in the DONE cycle also counts as busy.
- Width: internal x/y are Q_in+2 bits signed. CORDIC gain 1.647 times √2 times full scale must not overflow; I=Q=-2^(Q_in-1) must produce a correct result.
- Zero input (0,0): mag_out=0, phase_out=0.
- Accuracy (defaults):
  - mag_out within ±(0.05% + 2) LSB of the ideal value.
  - phase_out within ±3 LSB of the ideal value.

Test Plan:
- Reset, then pulse in_valid with I=1000, Q=0 → out_valid exactly 19 cycles after capture; mag_out≈1000 (±2); phase_out≈0 (±3); busy high during those cycles.
- I=0, Q=1000 → phase_out≈16384. I=-1000, Q=0 → phase_out≈-32768. I=1000, Q=-1000 → mag_out≈1414, phase_out≈-8192.
- I=Q=-2147483648 → mag_out≈3037000500 (±0.05%), phase_out≈-24576; no wrap or sign flip.
- Hold in_valid high for 100 cycles → exactly one out_valid pulse; overrun stays 0.
- Drop in_valid, then raise it again 5 cycles after capture while busy → still one out_valid, result from the first pair; overrun=1 and remains set until reset.
- Assert reset_n low during ITERATE → all outputs go to 0 immediately; no out_valid after release unless a new rising edge (or in_valid held high) occurs.
